// File: rtl/elevator_pkg.sv
// Shared types and default timing for the elevator scheduler slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package elevator_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        MOVE_UP   = 2'b01,
        MOVE_DOWN = 2'b10,
        DOOR_OPEN = 2'b11
    } state_t;

    localparam int DEF_NUM_FLOORS  = 16;
    localparam int DEF_FLOOR_W     = 4;
    localparam int DEF_MOVE_CYCLES = 4;
    localparam int DEF_DOOR_CYCLES = 8;

endpackage

// File: rtl/elevator_scheduler_if.sv
// Floor-call input and car status bundle between button decoder, scheduler and drive logic.
// Latency: n/a (wires only).
// Backpressure: none; req_valid is a strobe sampled on every edge.
interface elevator_scheduler_if #(
    parameter int NUM_FLOORS = 16,
    parameter int FLOOR_W    = 4
);
    logic                  req_valid;
    logic [FLOOR_W-1:0]    req_floor;
    logic [FLOOR_W-1:0]    car_floor;
    logic                  dir_up;
    logic                  moving;
    logic                  door_open;
    logic                  arrived;
    logic [NUM_FLOORS-1:0] pending;

    modport master (
        output req_valid, req_floor,
        input  car_floor, dir_up, moving, door_open, arrived, pending
    );

    modport slave (
        input  req_valid, req_floor,
        output car_floor, dir_up, moving, door_open, arrived, pending
    );
endinterface

// File: rtl/elevator_scan_lookup.sv
// Splits the pending-call bitmap around the car: any call above, below, or at the car floor.
// Latency: combinational.
// Backpressure: none.
module elevator_scan_lookup #(
    parameter int NUM_FLOORS = 16,
    parameter int FLOOR_W    = 4
) (
    input  logic [NUM_FLOORS-1:0] pending,
    input  logic [FLOOR_W-1:0]    car_floor,
    output logic                  above,
    output logic                  below,
    output logic                  here
);
    // OR-reduce the bitmap on each side of the car floor
    always_comb begin
        above = 1'b0;
        below = 1'b0;
        here  = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (i > int'(car_floor)) above = above | pending[i];
            if (i < int'(car_floor)) below = below | pending[i];
            if (i == int'(car_floor)) here = pending[i];
        end
    end
endmodule

// File: rtl/elevator_scheduler.sv
// SCAN call scheduler: latches floor calls, steps the car one floor per MOVE_CYCLES, opens door per stop.
// Latency: call in IDLE -> moving one edge later; first floor change MOVE_CYCLES edges after that.
// Backpressure: none; every strobe is captured, duplicates and out-of-range floors are absorbed.
module elevator_scheduler
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS  = DEF_NUM_FLOORS,
    parameter int FLOOR_W     = DEF_FLOOR_W,
    parameter int MOVE_CYCLES = DEF_MOVE_CYCLES,
    parameter int DOOR_CYCLES = DEF_DOOR_CYCLES
) (
    input  logic                 clk,
    input  logic                 reset,
    elevator_scheduler_if.slave  bus
);
    localparam int MOVE_W = (MOVE_CYCLES > 1) ? $clog2(MOVE_CYCLES) : 1;
    localparam int DOOR_W = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
    localparam logic [MOVE_W-1:0]  MOVE_LAST = MOVE_W'(MOVE_CYCLES - 1);
    localparam logic [DOOR_W-1:0]  DOOR_LAST = DOOR_W'(DOOR_CYCLES - 1);
    localparam logic [FLOOR_W-1:0] TOP_FLOOR = FLOOR_W'(NUM_FLOORS - 1);

    state_t                state;
    logic [FLOOR_W-1:0]    car_floor;
    logic [FLOOR_W-1:0]    next_floor;
    logic                  dir_up;
    logic                  moving;
    logic                  door_open;
    logic                  arrived;
    logic [NUM_FLOORS-1:0] pending;
    logic [NUM_FLOORS-1:0] set_vec;
    logic [NUM_FLOORS-1:0] clr_vec;
    logic [NUM_FLOORS-1:0] next_sel;
    logic [NUM_FLOORS-1:0] cur_sel;
    logic [MOVE_W-1:0]     move_tmr;
    logic [DOOR_W-1:0]     door_tmr;
    logic                  above;
    logic                  below;
    logic                  here;
    logic                  req_ok;
    logic                  req_here;
    logic                  step;
    logic                  hit_next;
    logic                  ahead;
    logic                  behind;

    elevator_scan_lookup #(
        .NUM_FLOORS (NUM_FLOORS),
        .FLOOR_W    (FLOOR_W)
    ) u_lookup (
        .pending   (pending),
        .car_floor (car_floor),
        .above     (above),
        .below     (below),
        .here      (here)
    );

    // Decode the incoming call and the floor the car is about to reach.
    // A call for the floor the car is parked or open at is served directly and never latched.
    always_comb begin
        req_ok     = bus.req_valid && (int'(bus.req_floor) < NUM_FLOORS);
        req_here   = req_ok && (bus.req_floor == car_floor) &&
                     ((state == IDLE) || (state == DOOR_OPEN));
        step       = ((state == MOVE_UP) || (state == MOVE_DOWN)) && (move_tmr == MOVE_LAST);
        next_floor = (state == MOVE_UP) ? car_floor + FLOOR_W'(1) : car_floor - FLOOR_W'(1);
        ahead      = dir_up ? above : below;
        behind     = dir_up ? below : above;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            next_sel[i] = (FLOOR_W'(i) == next_floor);
            cur_sel[i]  = (FLOOR_W'(i) == car_floor);
            set_vec[i]  = req_ok && !req_here && (FLOOR_W'(i) == bus.req_floor);
        end
        hit_next = |(pending & next_sel);
    end

    // Pick the bit being served this edge; clearing overrides a same-edge set of that floor
    always_comb begin
        clr_vec = '0;
        if (step && hit_next)
            clr_vec = next_sel;
        else if ((state == IDLE) && here)
            clr_vec = cur_sel;
    end

    // Car sequencer: pending capture, SCAN direction choice, move and door timers
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            car_floor <= '0;
            dir_up    <= 1'b1;
            moving    <= 1'b0;
            door_open <= 1'b0;
            arrived   <= 1'b0;
            pending   <= '0;
            move_tmr  <= '0;
            door_tmr  <= '0;
        end else begin
            pending <= (pending | set_vec) & ~clr_vec;
            arrived <= 1'b0;
            case (state)
                IDLE: begin
                    if (here || req_here) begin
                        state     <= DOOR_OPEN;
                        door_open <= 1'b1;
                        arrived   <= 1'b1;
                        door_tmr  <= '0;
                    end else if (above && (dir_up || !below)) begin
                        state    <= MOVE_UP;
                        dir_up   <= 1'b1;
                        moving   <= 1'b1;
                        move_tmr <= '0;
                    end else if (below) begin
                        state    <= MOVE_DOWN;
                        dir_up   <= 1'b0;
                        moving   <= 1'b1;
                        move_tmr <= '0;
                    end
                end
                MOVE_UP, MOVE_DOWN: begin
                    if (step) begin
                        car_floor <= next_floor;
                        move_tmr  <= '0;
                        if (hit_next) begin
                            state     <= DOOR_OPEN;
                            moving    <= 1'b0;
                            door_open <= 1'b1;
                            arrived   <= 1'b1;
                            door_tmr  <= '0;
                        end
                    end else begin
                        move_tmr <= move_tmr + MOVE_W'(1);
                    end
                end
                DOOR_OPEN: begin
                    if (req_here) begin
                        door_tmr <= '0;
                    end else if (door_tmr == DOOR_LAST) begin
                        door_open <= 1'b0;
                        if (ahead) begin
                            state    <= dir_up ? MOVE_UP : MOVE_DOWN;
                            moving   <= 1'b1;
                            move_tmr <= '0;
                        end else if (behind) begin
                            state    <= dir_up ? MOVE_DOWN : MOVE_UP;
                            dir_up   <= !dir_up;
                            moving   <= 1'b1;
                            move_tmr <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        door_tmr <= door_tmr + DOOR_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A move is only started toward a pending call, so it never runs off either end
    assert property (@(posedge clk) disable iff (reset)
        (state == MOVE_UP) |-> (car_floor != TOP_FLOOR));
    assert property (@(posedge clk) disable iff (reset)
        (state == MOVE_DOWN) |-> (car_floor != '0));

    assign bus.car_floor = car_floor;
    assign bus.dir_up    = dir_up;
    assign bus.moving    = moving;
    assign bus.door_open = door_open;
    assign bus.arrived   = arrived;
    assign bus.pending   = pending;

endmodule
